// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: watches the step counter's index, looks up a
// per-track pattern bit and emits fixed-length trigger pulses.
// The pattern store, run/stop control, per-track mute and per-track
// trigger-length timers all live here.
module drum_step_sequencer #(
  parameter int TRACKS = 4,
  parameter int STEP_W = 4,
  parameter int LEN_W  = 8,
  localparam int TW    = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [LEN_W-1:0]  trig_len_i,
  input  logic [TRACKS-1:0] mute_i,
  input  logic              wr_en_i,
  input  logic [TW-1:0]     wr_track_i,
  input  logic [STEP_W-1:0] wr_step_i,
  input  logic              wr_val_i,
  output logic [TRACKS-1:0] trig_o,
  output logic              step_fire_o,
  output logic              running_o
);

  localparam int STEPS = 2 ** STEP_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic                         entry_q, entry_d;
  logic [STEP_W-1:0]            step_q, step_d;
  logic [TRACKS-1:0][STEPS-1:0] pattern_q, pattern_d;
  logic [TRACKS-1:0][LEN_W-1:0] timer_q, timer_d;
  logic [TRACKS-1:0]            trig_q, trig_d;
  logic                         step_fire_q, step_fire_d;

  logic                         run_active;
  logic                         fire;
  logic [TRACKS-1:0]            hit;
  logic [LEN_W-1:0]             len_eff;

  // Run/stop control; entering RUN raises a one-cycle flag so the first
  // cycle in RUN fires even when the step index has not moved.
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = RUN;
          entry_d = 1'b1;
        end
      end
      RUN: begin
        if (!run_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fire detection: a new step (or the entry cycle) while still running;
  // the pattern lookup reads the stored bit, so a same-cycle write is not seen.
  always_comb begin
    run_active  = (state_q == RUN) && run_i;
    fire        = run_active && (entry_q || (step_i != step_q));
    step_d      = fire ? step_i : step_q;
    step_fire_d = fire;
    len_eff     = (trig_len_i == '0) ? LEN_W'(1) : trig_len_i;
    hit         = '0;
    for (int t = 0; t < TRACKS; t++) begin
      hit[t] = pattern_q[t][step_i] & ~mute_i[t];
    end
  end

  // Pattern writes are accepted in any state; track indices past TRACKS match nothing.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en_i) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (wr_track_i == TW'(t)) begin
          pattern_d[t][wr_step_i] = wr_val_i;
        end
      end
    end
  end

  // Per-track length timers: reload on a hit, count down otherwise, and
  // clear together the moment playback stops.
  always_comb begin
    timer_d = timer_q;
    trig_d  = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (!run_active) begin
        timer_d[t] = '0;
      end else if (fire && hit[t]) begin
        timer_d[t] = len_eff;
      end else if (timer_q[t] != '0) begin
        timer_d[t] = timer_q[t] - LEN_W'(1);
      end
      trig_d[t] = (timer_d[t] != '0);
    end
  end

  // State and datapath registers; reset clears everything including the pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      entry_q     <= 1'b0;
      step_q      <= '0;
      pattern_q   <= '0;
      timer_q     <= '0;
      trig_q      <= '0;
      step_fire_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      step_q      <= step_d;
      pattern_q   <= pattern_d;
      timer_q     <= timer_d;
      trig_q      <= trig_d;
      step_fire_q <= step_fire_d;
    end
  end

  assign trig_o      = trig_q;
  assign step_fire_o = step_fire_q;
  assign running_o   = (state_q == RUN);

endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

- Pattern-trigger stage that sits directly downstream of the step counter.
- Watches the counter's step index and looks up a per-track, per-step pattern bit.
- Emits fixed-length trigger pulses to the drum voice generators.
- Holds the pattern store, a run/stop state machine, per-track mute, and per-track trigger-length timers.

## Interface

Parameters:
- TRACKS, default 4: number of drum tracks / trigger outputs.
- STEP_W, default 4: step index width; the pattern holds 2^STEP_W steps per track.
- LEN_W, default 8: trigger-length counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- run_i, in, 1: level; 1 = play, 0 = stop.
- step_i, in, STEP_W: current step from the step counter.
- trig_len_i, in, LEN_W: trigger pulse length in clk cycles; 0 is treated as 1.
- mute_i, in, TRACKS: per-track mute, 1 = muted.
- wr_en_i, in, 1: pattern write strobe.
- wr_track_i, in, clog2(TRACKS) (min 1): track to write.
- wr_step_i, in, STEP_W: step to write.
- wr_val_i, in, 1: pattern bit to write.
- trig_o, out, TRACKS: trigger pulses to the voices.
- step_fire_o, out, 1: one-cycle pulse each time a step is evaluated.
- running_o, out, 1: 1 while in RUN.

## Operation

Pattern store:
- TRACKS x 2^STEP_W bits, held in flops.
- Cleared to 0 by rst.
- Written on any cycle wr_en_i=1, in any state.
- wr_track_i >= TRACKS is ignored.

State machine:
- Two states: IDLE, RUN. Reset state is IDLE.
- IDLE -> RUN when run_i=1. The entry cycle is itself a fire event for the current step_i.
- RUN -> IDLE when run_i=0. All trig_o and length timers clear on the following edge; the pattern is retained.

Step detection:
- step_q register holds the last evaluated step; reset value 0.
- In RUN, a fire event occurs on any cycle where step_i != step_q.
- step_q loads step_i on every fire event.
- Wrap from 2^STEP_W-1 (or n-1) to 0 is an ordinary change and fires.
- If step_i changes back to the same value across a stop/start, the start event still fires.

Fire event:
- For each track t, hit[t] = pattern[t][step_i] & ~mute_i[t].
- For each hit track, load the timer with max(trig_len_i,1) and drive trig_o[t] high.
- Non-hit tracks keep their current timer.

Timers:
- Each decrements by 1 per cycle while nonzero.
- trig_o[t] = (timer[t] != 0), registered.

Boundary cases:
- Retrigger while active: the timer reloads and trig_o stays high with no gap.
- Mute asserted mid-pulse: the pulse completes; only new fires are suppressed.
- Write to the cell being fired in the same cycle: the fire uses the old value; the new value applies from the next cycle.
- trig_len_i is sampled only at fire; changes mid-pulse do not affect the active pulse.
- rst mid-pulse: all outputs go to 0 immediately (asynchronously); the pattern clears.

## Timing

- Reset values:
  - trig_o = 0, step_fire_o = 0, running_o = 0
  - state = IDLE, step_q = 0, timers = 0, pattern = 0
- Latency:
  - step_i change visible at edge k -> trig_o and step_fire_o high after edge k+1.
  - trig_o stays high for exactly L = max(trig_len_i,1) cycles.
- run_i rising sampled at edge k:
  - running_o = 1 after edge k.
  - The fire for the current step_i occurs at edge k+1.
- run_i falling sampled at edge k:
  - running_o = 0 and trig_o = 0 after edge k.
  - A step change in that same cycle does not fire.
- Maximum step rate: one step change per cycle is evaluated without loss.

## Test plan

1. Reset → all outputs 0; reading back any step after start produces no triggers (pattern cleared).
2. Write pattern[0][0]=1 and pattern[2][3]=1, set trig_len_i=5, run_i=1 with step_i=0 → trig_o=4'b0001 for 5 cycles starting 2 cycles after run. Advance step_i to 3 → trig_o=4'b0100 for 5 cycles and one step_fire_o pulse.
3. Retrigger: trig_len_i=10, track 1 set on steps 1 and 2, step_i advances 1→2 three cycles apart → trig_o[1] high continuously for 13 cycles.
4. Mute: mute_i=4'b0001 with pattern[0][all]=1, stepping 0..15 → trig_o[0] never rises, while step_fire_o still pulses 16 times. Unmute during a pulse → no effect until the next fire.
5. Wrap and stop: step_i 15→0 → fires step 0. Drop run_i with trig_o[2] active → trig_o=0 next cycle, running_o=0, and later step changes produce no fire.
6. Edge cases: trig_len_i=0 → 1-cycle pulse. Write-same-cycle collision on a firing cell uses the old value. rst asserted mid-pulse → trig_o=0 without waiting for a clock edge.
